// File: rtl/wfg_interconnect_xbar.sv
// wfg_interconnect_xbar: NUM_STIM x NUM_DRV AXI-Stream crossbar from waveform stimuli to drivers.
// Each driver selects one stimulus (or none) and owns a 2-entry skid buffer. Because of the
// buffer, stimulus tready depends only on registered buffer state, never on driver tready.
// When one stimulus feeds several drivers, per-driver accept flags make sure every selected
// driver takes the beat exactly once before the stimulus is released.
module wfg_interconnect_xbar #(
  parameter int NUM_STIM        = 2,
  parameter int NUM_DRV         = 2,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int SEL_WIDTH       = $clog2(NUM_STIM + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ctrl_en_q_i,
  input  logic [NUM_DRV*SEL_WIDTH-1:0]         drv_select_q_i,
  input  logic [NUM_STIM-1:0]                  stim_tvalid_i,
  input  logic [NUM_STIM*AXIS_DATA_WIDTH-1:0]  stim_tdata_i,
  output logic [NUM_STIM-1:0]                  stim_tready_o,
  output logic [NUM_DRV-1:0]                   drv_tvalid_o,
  output logic [NUM_DRV*AXIS_DATA_WIDTH-1:0]   drv_tdata_o,
  input  logic [NUM_DRV-1:0]                   drv_tready_i,
  output logic [NUM_DRV-1:0]                   drv_active_o
);
  localparam int W = AXIS_DATA_WIDTH;
  localparam logic [SEL_WIDTH-1:0] SEL_NONE = SEL_WIDTH'(NUM_STIM);

  logic [NUM_DRV-1:0][SEL_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_DRV-1:0]                acc_q, acc_d;
  logic [NUM_DRV-1:0][1:0][W-1:0]    mem_q, mem_d;
  logic [NUM_DRV-1:0]                wr_ptr_q, wr_ptr_d;
  logic [NUM_DRV-1:0]                rd_ptr_q, rd_ptr_d;
  logic [NUM_DRV-1:0][1:0]           cnt_q, cnt_d;

  logic [NUM_DRV-1:0]                src_vld, src_fire, push, pop;
  logic [NUM_DRV-1:0][W-1:0]         src_dat;

  // Mux the selected stimulus onto each driver; out-of-range selects stay idle
  always_comb begin
    src_vld = '0;
    src_dat = '0;
    for (int d = 0; d < NUM_DRV; d++) begin
      for (int s = 0; s < NUM_STIM; s++) begin
        if (sel_q[d] == SEL_WIDTH'(s)) begin
          src_vld[d] = stim_tvalid_i[s];
          src_dat[d] = stim_tdata_i[s*W +: W];
        end
      end
    end
  end

  // Push/pop per skid buffer; fullness uses the registered count so a same-cycle pop can't unblock
  always_comb begin
    push = '0;
    pop  = '0;
    for (int d = 0; d < NUM_DRV; d++) begin
      push[d] = ctrl_en_q_i & src_vld[d] & (cnt_q[d] != 2'd2) & ~acc_q[d];
      pop[d]  = (cnt_q[d] != 2'd0) & drv_tready_i[d];
    end
  end

  // A stimulus is released once every driver in its fan-out has taken or is taking the beat
  always_comb begin
    logic any_sel;
    logic all_acc;
    stim_tready_o = '0;
    for (int s = 0; s < NUM_STIM; s++) begin
      any_sel = 1'b0;
      all_acc = 1'b1;
      for (int d = 0; d < NUM_DRV; d++) begin
        if (sel_q[d] == SEL_WIDTH'(s)) begin
          any_sel = 1'b1;
          if (!(acc_q[d] | push[d])) all_acc = 1'b0;
        end
      end
      stim_tready_o[s] = ctrl_en_q_i & any_sel & all_acc;
    end
  end

  // Flag per driver whether its selected stimulus completes a handshake this cycle
  always_comb begin
    src_fire = '0;
    for (int d = 0; d < NUM_DRV; d++) begin
      for (int s = 0; s < NUM_STIM; s++) begin
        if (sel_q[d] == SEL_WIDTH'(s)) src_fire[d] = stim_tvalid_i[s] & stim_tready_o[s];
      end
    end
  end

  // Next-state for select shadow, accept flags and skid buffers
  always_comb begin
    sel_d    = sel_q;
    acc_d    = acc_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    for (int d = 0; d < NUM_DRV; d++) begin
      if (!ctrl_en_q_i) sel_d[d] = drv_select_q_i[d*SEL_WIDTH +: SEL_WIDTH];
      if (!ctrl_en_q_i)     acc_d[d] = 1'b0;
      else if (src_fire[d]) acc_d[d] = 1'b0;
      else if (push[d])     acc_d[d] = 1'b1;
      if (push[d]) mem_d[d][wr_ptr_q[d]] = src_dat[d];
      cnt_d[d] = cnt_q[d] + {1'b0, push[d]} - {1'b0, pop[d]};
    end
  end

  // Driver side reads straight from registered buffer state
  always_comb begin
    drv_tdata_o = '0;
    for (int d = 0; d < NUM_DRV; d++) begin
      drv_tvalid_o[d] = (cnt_q[d] != 2'd0);
      drv_active_o[d] = (cnt_q[d] != 2'd0);
      if (cnt_q[d] != 2'd0) drv_tdata_o[d*W +: W] = mem_q[d][rd_ptr_q[d]];
    end
  end

  // State registers; reset empties buffers and disconnects every driver
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= {NUM_DRV{SEL_NONE}};
      acc_q    <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wfg_interconnect_xbar.sv
// Bench for wfg_interconnect_xbar (2 stimuli x 2 drivers, 32-bit data): cycle table plus
// directed sequences for streaming, backpressure, enable/select and fan-out re-delivery.
module tb_wfg_interconnect_xbar;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  sel;
  logic [1:0]  tv, tr;
  logic [63:0] td;
  logic [1:0]  srdy, dv, act;
  logic [63:0] dd;

  wfg_interconnect_xbar #(.NUM_STIM(2), .NUM_DRV(2), .AXIS_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ctrl_en_q_i(en), .drv_select_q_i(sel),
    .stim_tvalid_i(tv), .stim_tdata_i(td), .stim_tready_o(srdy),
    .drv_tvalid_o(dv), .drv_tdata_o(dd), .drv_tready_i(tr), .drv_active_o(act)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic en; logic [3:0] sel; logic [1:0] tv;
    logic [31:0] td0; logic [31:0] td1; logic [1:0] tr;
    logic [1:0] srdy; logic [1:0] dv; logic [31:0] d0; logic [31:0] d1;
    logic [1:0] act; logic dz;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic r, logic e, logic [3:0] s, logic [1:0] v, logic [31:0] a,
                              logic [31:0] b, logic [1:0] t, logic [1:0] er, logic [1:0] ev,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] ea, logic z);
    vec_t x;
    x.rst = r; x.en = e; x.sel = s; x.tv = v; x.td0 = a; x.td1 = b; x.tr = t;
    x.srdy = er; x.dv = ev; x.d0 = e0; x.d1 = e1; x.act = ea; x.dz = z;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the falling edge for checks
  task automatic apply(input logic r, input logic e, input logic [3:0] s, input logic [1:0] v,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
    @(posedge clk); #1;
    rst = r; en = e; sel = s; tv = v; td = {b, a}; tr = t;
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 4'b1111, 2'b00, 32'h0, 32'h0, 2'b00);
    apply(1'b1, 1'b0, 4'b1111, 2'b00, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int sent, rcv, cyc;
    logic r0;
    rst = 1'b1; en = 1'b0; sel = 4'b0; tv = 2'b0; td = 64'h0; tr = 2'b0;

    // Reset: two cycles, everything reads 0
    do_reset();
    chk("rst_srdy", srdy, 2'b00); chk("rst_dv", dv, 2'b00);
    chk("rst_data", dd, 64'h0);   chk("rst_act", act, 2'b00);

    //            rst  en  sel      tv     td0            td1            tr    srdy   dv     d0             d1             act    dz
    vecs.push_back(mk(1, 0, 4'b0100, 2'b11, 32'hA5A50001, 32'h5A5A0001, 2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 1));
    vecs.push_back(mk(0, 0, 4'b0100, 2'b11, 32'hA5A50001, 32'h5A5A0001, 2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 1));
    vecs.push_back(mk(0, 1, 4'b0100, 2'b11, 32'hA5A50001, 32'h5A5A0001, 2'b11, 2'b11, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 2'b11, 32'hA5A50002, 32'h5A5A0002, 2'b11, 2'b11, 2'b11, 32'hA5A50001, 32'h5A5A0001, 2'b11, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 2'b11, 32'hA5A50003, 32'h5A5A0003, 2'b11, 2'b00, 2'b11, 32'hA5A50002, 32'h5A5A0002, 2'b11, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 2'b00, 32'h0,        32'h0,        2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    // fan-out, driver 1 stalled for five cycles
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h1,        32'h0,        2'b01, 2'b01, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h2,        32'h0,        2'b01, 2'b01, 2'b11, 32'h1,        32'h1,        2'b11, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h3,        32'h0,        2'b01, 2'b00, 2'b11, 32'h2,        32'h1,        2'b11, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h3,        32'h0,        2'b01, 2'b00, 2'b11, 32'h3,        32'h1,        2'b11, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h3,        32'h0,        2'b01, 2'b00, 2'b10, 32'h0,        32'h1,        2'b10, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h3,        32'h0,        2'b11, 2'b00, 2'b10, 32'h0,        32'h1,        2'b10, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b01, 32'h3,        32'h0,        2'b11, 2'b01, 2'b10, 32'h0,        32'h2,        2'b10, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b00, 32'h0,        32'h0,        2'b11, 2'b00, 2'b10, 32'h0,        32'h3,        2'b10, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b00, 32'h0,        32'h0,        2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    // unconnected drivers: stimulus never released
    vecs.push_back(mk(0, 0, 4'b1010, 2'b01, 32'h77,       32'h0,        2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 2'b01, 32'h77,       32'h0,        2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 2'b01, 32'h77,       32'h0,        2'b11, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    // fill both buffers, then reset mid-stream
    vecs.push_back(mk(0, 0, 4'b0100, 2'b11, 32'hA5A5000A, 32'h5A5A000A, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 2'b11, 32'hA5A5000A, 32'h5A5A000A, 2'b00, 2'b11, 2'b00, 32'h0,        32'h0,        2'b00, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 2'b11, 32'hA5A5000B, 32'h5A5A000B, 2'b00, 2'b11, 2'b11, 32'hA5A5000A, 32'h5A5A000A, 2'b11, 0));
    vecs.push_back(mk(1, 1, 4'b0100, 2'b11, 32'hA5A5000C, 32'h5A5A000C, 2'b00, 2'b00, 2'b11, 32'hA5A5000A, 32'h5A5A000A, 2'b11, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 2'b11, 32'hA5A5000C, 32'h5A5A000C, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 1));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].tv, vecs[i].td0, vecs[i].td1, vecs[i].tr);
      chk($sformatf("vec%0d_srdy", i), srdy, vecs[i].srdy);
      chk($sformatf("vec%0d_dv", i), dv, vecs[i].dv);
      chk($sformatf("vec%0d_act", i), act, vecs[i].act);
      if (vecs[i].dv[0] || vecs[i].dz) chk($sformatf("vec%0d_d0", i), dd[31:0], vecs[i].d0);
      if (vecs[i].dv[1] || vecs[i].dz) chk($sformatf("vec%0d_d1", i), dd[63:32], vecs[i].d1);
    end

    // 1:1 streaming, 16 beats each, one cycle late, no gaps
    do_reset();
    apply(1'b0, 1'b0, 4'b0100, 2'b00, 32'h0, 32'h0, 2'b11);
    for (int i = 0; i <= 16; i++) begin
      apply(1'b0, 1'b1, 4'b0100, (i < 16) ? 2'b11 : 2'b00,
            32'hA5A50001 + 32'(i), 32'h5A5A0001 + 32'(i), 2'b11);
      if (i < 16) chk("t2_srdy", srdy, 2'b11);
      if (i > 0) begin
        chk("t2_dv", dv, 2'b11);
        chk("t2_d0", dd[31:0], 32'hA5A50001 + 32'(i - 1));
        chk("t2_d1", dd[63:32], 32'h5A5A0001 + 32'(i - 1));
      end
    end

    // Toggling backpressure on driver 0; stimulus tready must ignore drv tready
    do_reset();
    apply(1'b0, 1'b0, 4'b1100, 2'b00, 32'h0, 32'h0, 2'b11);
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 300) begin
      apply(1'b0, 1'b1, 4'b1100, (sent < 20) ? 2'b01 : 2'b00,
            32'hB0000000 + 32'(sent), 32'h0, {1'b1, cyc[0]});
      if (tv[0]) begin
        r0 = srdy[0];
        tr[0] = ~tr[0];
        #1;
        chk("t5_comb", srdy[0], r0);
        tr[0] = ~tr[0];
      end
      #1;
      chk("t5_d1_idle", dv[1], 1'b0);
      if (dv[0] && tr[0]) begin
        chk("t5_data", dd[31:0], 32'hB0000000 + 32'(rcv));
        rcv++;
      end
      if (tv[0] && srdy[0]) sent++;
      cyc++;
    end
    chk("t5_count", rcv, 20);

    // Select frozen while enabled, drain on disable, new select on re-enable
    do_reset();
    apply(1'b0, 1'b0, 4'b0100, 2'b00, 32'h0, 32'h0, 2'b00);
    apply(1'b0, 1'b1, 4'b0001, 2'b01, 32'hC0DE0001, 32'h0, 2'b00);
    chk("t6_frozen_srdy", srdy, 2'b01);
    apply(1'b0, 1'b1, 4'b0001, 2'b00, 32'h0, 32'h0, 2'b00);
    chk("t6_frozen_dv", dv, 2'b01);
    chk("t6_frozen_d0", dd[31:0], 32'hC0DE0001);
    apply(1'b0, 1'b0, 4'b0001, 2'b01, 32'hC0DE0002, 32'h0, 2'b01);
    chk("t6_off_srdy", srdy, 2'b00);
    chk("t6_off_dv", dv, 2'b01);
    apply(1'b0, 1'b0, 4'b0001, 2'b00, 32'h0, 32'h0, 2'b11);
    chk("t6_drained", act, 2'b00);
    apply(1'b0, 1'b1, 4'b0001, 2'b01, 32'hC0DE0002, 32'h0, 2'b11);
    chk("t6_newsel_srdy", srdy, 2'b01);
    apply(1'b0, 1'b1, 4'b0001, 2'b00, 32'h0, 32'h0, 2'b11);
    chk("t6_newsel_dv", dv, 2'b10);
    chk("t6_newsel_d1", dd[63:32], 32'hC0DE0002);

    // Disable mid-fan-out: the beat is re-delivered to both drivers after re-enable
    apply(1'b0, 1'b0, 4'b0000, 2'b00, 32'h0, 32'h0, 2'b11);
    apply(1'b0, 1'b1, 4'b0000, 2'b01, 32'hD0000001, 32'h0, 2'b01);
    apply(1'b0, 1'b1, 4'b0000, 2'b01, 32'hD0000002, 32'h0, 2'b01);
    apply(1'b0, 1'b1, 4'b0000, 2'b01, 32'hD0000003, 32'h0, 2'b01);
    chk("dup_stall_srdy", srdy, 2'b00);
    chk("dup_d0_b2", dd[31:0], 32'hD0000002);
    apply(1'b0, 1'b0, 4'b0000, 2'b01, 32'hD0000003, 32'h0, 2'b01);
    chk("dup_off_srdy", srdy, 2'b00);
    chk("dup_d0_first", dd[31:0], 32'hD0000003);
    apply(1'b0, 1'b0, 4'b0000, 2'b01, 32'hD0000003, 32'h0, 2'b11);
    chk("dup_d1_b1", dd[63:32], 32'hD0000001);
    apply(1'b0, 1'b0, 4'b0000, 2'b01, 32'hD0000003, 32'h0, 2'b11);
    chk("dup_d1_b2", dd[63:32], 32'hD0000002);
    apply(1'b0, 1'b1, 4'b0000, 2'b01, 32'hD0000003, 32'h0, 2'b11);
    chk("dup_reen_srdy", srdy, 2'b01);
    chk("dup_reen_dv", dv, 2'b00);
    apply(1'b0, 1'b1, 4'b0000, 2'b00, 32'h0, 32'h0, 2'b11);
    chk("dup_dv", dv, 2'b11);
    chk("dup_d0_again", dd[31:0], 32'hD0000003);
    chk("dup_d1_b3", dd[63:32], 32'hD0000003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
